// File: rtl/dll_tx_updatefc_sched.sv
// UpdateFC DLLP scheduler: tracks advertised credits per (VC, FC type) slot and
// launches one UpdateFC per handshake, round-robin over slots needing an update.
module dll_tx_updatefc_sched #(
  parameter int NUM_VC    = 2,
  parameter int TIMER_CYC = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              dlc_state_i,
  input  logic [NUM_VC*3*8-1:0]   hdr_credit_i,
  input  logic [NUM_VC*3*12-1:0]  data_credit_i,
  output logic [135:0]            dllp_o,
  output logic                    dllp_valid_o,
  input  logic                    dllp_ready_i
);

  localparam int NS = NUM_VC * 3;
  localparam int SW = $clog2(NS);
  localparam int TW = $clog2(TIMER_CYC);

  logic                active;
  logic                active_q;
  logic                rise;
  logic [TW-1:0]       timer;
  logic                timer_wrap;
  logic [NS-1:0]       pending;
  logic [NS-1:0]       pending_nxt;
  logic [NS-1:0]       mismatch;
  logic [NS*8-1:0]     snap_hdr;
  logic [NS*12-1:0]    snap_data;
  logic [SW-1:0]       rr_ptr;
  logic [SW-1:0]       sel;
  logic [SW:0]         idx;
  logic                found;
  logic                launch;
  logic [7:0]          sel_hdr;
  logic [11:0]         sel_data;
  logic [2:0]          sel_vc;
  logic [1:0]          sel_type;
  logic [3:0]          type_code;
  logic [47:0]         payload;

  assign active     = (dlc_state_i == 2'b11);
  assign rise       = active && !active_q;
  assign timer_wrap = (timer == TW'(TIMER_CYC - 1));

  always_comb begin
    mismatch = '0;
    for (int s = 0; s < NS; s++) begin
      mismatch[s] = (hdr_credit_i[s*8 +: 8] != snap_hdr[s*8 +: 8]) ||
                    (data_credit_i[s*12 +: 12] != snap_data[s*12 +: 12]);
    end
  end

  // First pending slot at or above rr_ptr, wrapping past the last slot.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NS; i++) begin
      idx = {1'b0, rr_ptr} + (SW+1)'(i);
      if (idx >= (SW+1)'(NS)) idx = idx - (SW+1)'(NS);
      if (!found && pending[idx[SW-1:0]]) begin
        found = 1'b1;
        sel   = idx[SW-1:0];
      end
    end
  end

  assign launch = active && (!dllp_valid_o || dllp_ready_i) && found;

  // A launched slot's own mismatch is resolved by the snapshot it writes; a
  // timer wrap on the same edge still re-pends it.
  always_comb begin
    pending_nxt = '0;
    for (int s = 0; s < NS; s++) begin
      pending_nxt[s] = ((pending[s] || mismatch[s]) && !(launch && sel == SW'(s))) ||
                       rise || timer_wrap;
    end
  end

  always_comb begin
    sel_hdr   = hdr_credit_i[32'(sel)*8 +: 8];
    sel_data  = data_credit_i[32'(sel)*12 +: 12];
    sel_vc    = 3'(sel / SW'(3));
    sel_type  = 2'(sel % SW'(3));
    type_code = 4'h8;
    case (sel_type)
      2'd0:    type_code = 4'h8;
      2'd1:    type_code = 4'hA;
      default: type_code = 4'h9;
    endcase
    payload = {type_code, 1'b0, sel_vc,
               2'b00, sel_hdr[7:2],
               sel_hdr[1:0], 2'b00, sel_data[11:8],
               sel_data[7:0],
               16'h0000};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q     <= 1'b0;
      timer        <= '0;
      pending      <= '0;
      snap_hdr     <= '0;
      snap_data    <= '0;
      rr_ptr       <= '0;
      dllp_o       <= '0;
      dllp_valid_o <= 1'b0;
    end else if (!active) begin
      active_q     <= 1'b0;
      timer        <= '0;
      pending      <= '0;
      snap_hdr     <= '0;
      snap_data    <= '0;
      rr_ptr       <= '0;
      dllp_valid_o <= 1'b0;
    end else begin
      active_q <= 1'b1;
      timer    <= timer_wrap ? '0 : timer + 1'b1;
      pending  <= pending_nxt;
      if (launch) begin
        dllp_o                      <= {payload, 88'h0};
        dllp_valid_o                <= 1'b1;
        snap_hdr[32'(sel)*8 +: 8]   <= sel_hdr;
        snap_data[32'(sel)*12 +: 12] <= sel_data;
        rr_ptr                      <= (sel == SW'(NS - 1)) ? '0 : sel + 1'b1;
      end else if (dllp_ready_i) begin
        dllp_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dll_tx_updatefc_sched.sv
// Bench for dll_tx_updatefc_sched: reference model feeds an expected-DLLP queue,
// a monitor pops it each time the DUT presents a new DLLP.
module tb_dll_tx_updatefc_sched;
  localparam int NUM_VC    = 2;
  localparam int NS        = NUM_VC * 3;
  localparam int TIMER_CYC = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         dlc_state;
  logic [NS*8-1:0]    hdr_credit;
  logic [NS*12-1:0]   data_credit;
  logic [135:0]       dllp;
  logic               dllp_valid;
  logic               dllp_ready;

  int errors = 0;
  int checks = 0;

  dll_tx_updatefc_sched #(.NUM_VC(NUM_VC), .TIMER_CYC(TIMER_CYC)) dut (
    .clk          (clk),
    .rst          (rst),
    .dlc_state_i  (dlc_state),
    .hdr_credit_i (hdr_credit),
    .data_credit_i(data_credit),
    .dllp_o       (dllp),
    .dllp_valid_o (dllp_valid),
    .dllp_ready_i (dllp_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [135:0] mk_dllp(input int s, input int h, input int d);
    int vc, ty, code;
    logic [47:0] p;
    vc   = s / 3;
    ty   = s % 3;
    code = (ty == 0) ? 8 : (ty == 1) ? 10 : 9;
    p = {8'(code * 16 + vc), 8'(h >> 2), 8'(((h & 3) << 6) | (d >> 8)), 8'(d & 255), 16'h0000};
    return {p, 88'h0};
  endfunction

  // ---------------- reference model ----------------
  bit              m_pend [NS];
  int              m_snap_h [NS];
  int              m_snap_d [NS];
  int              m_timer;
  int              m_rr;
  bit              m_valid;
  bit              m_prev_active;
  logic [135:0]    exp_q [$];

  always @(posedge clk) begin
    bit act, wrap;
    bit mis [NS];
    int sel, s, h, d;
    act = (dlc_state == 2'b11);
    if (rst || !act) begin
      for (int k = 0; k < NS; k++) begin
        m_pend[k] = 0; m_snap_h[k] = 0; m_snap_d[k] = 0;
      end
      m_timer = 0; m_rr = 0; m_valid = 0; m_prev_active = 0;
    end else begin
      wrap    = (m_timer == TIMER_CYC - 1);
      m_timer = wrap ? 0 : m_timer + 1;
      for (int k = 0; k < NS; k++)
        mis[k] = (int'(hdr_credit[k*8 +: 8]) != m_snap_h[k]) ||
                 (int'(data_credit[k*12 +: 12]) != m_snap_d[k]);
      if (!m_valid || dllp_ready) begin
        m_valid = 0;
        sel = -1;
        for (int i = 0; i < NS; i++) begin
          s = (m_rr + i) % NS;
          if (sel < 0 && m_pend[s]) sel = s;
        end
        if (sel >= 0) begin
          h = int'(hdr_credit[sel*8 +: 8]);
          d = int'(data_credit[sel*12 +: 12]);
          exp_q.push_back(mk_dllp(sel, h, d));
          m_snap_h[sel] = h;
          m_snap_d[sel] = d;
          m_pend[sel]   = 0;
          mis[sel]      = 0;
          m_valid       = 1;
          m_rr          = (sel + 1) % NS;
        end
      end
      for (int k = 0; k < NS; k++)
        if (!m_prev_active || mis[k] || wrap) m_pend[k] = 1;
      m_prev_active = 1;
    end
  end

  // ---------------- monitor ----------------
  logic [135:0] held;
  always @(posedge clk) begin
    bit fire, pv;
    logic [135:0] e;
    fire = dllp_valid && dllp_ready;
    pv   = dllp_valid;
    #1;
    check("valid", dllp_valid, m_valid);
    if (dllp_valid) begin
      if (fire || !pv) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL dllp_unexpected: got %h expected none", dllp);
        end else begin
          e = exp_q.pop_front();
          check("dllp", dllp, e);
        end
        held = dllp;
      end else begin
        check("dllp_hold", dllp, held);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int off_cnt, slot, waited;
    rst = 1'b1; dlc_state = 2'b00; dllp_ready = 1'b1;
    for (int k = 0; k < NS; k++) begin
      hdr_credit[k*8 +: 8]    = 8'h20;
      data_credit[k*12 +: 12] = 12'h080;
    end
    repeat (3) @(negedge clk);
    check("reset_dllp", dllp, 136'h0);
    check("reset_valid", dllp_valid, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // DL_Active entry: slots 0..5 back to back
    dlc_state = 2'b11;
    @(posedge clk);
    @(posedge clk); #1;
    check("entry_valid", dllp_valid, 1'b1);
    check("entry_slot0", dllp[135:88], 48'h80_08_00_80_00_00);
    repeat (4) @(posedge clk); #1;
    check("slot4_byte0", dllp[135:128], 8'hA1);
    repeat (2) @(posedge clk); #1;
    check("idle_after_burst", dllp_valid, 1'b0);

    // single credit change, 2-cycle latency
    @(negedge clk);
    hdr_credit[2*8 +: 8] = 8'h21;
    @(posedge clk);
    @(posedge clk); #1;
    check("slot2_update_valid", dllp_valid, 1'b1);
    check("slot2_update", dllp[135:88], 48'h90_08_40_80_00_00);
    @(posedge clk); #1;
    check("slot2_single", dllp_valid, 1'b0);

    // backpressure while slots 1 and 3 change
    @(negedge clk);
    dllp_ready = 1'b0;
    hdr_credit[1*8 +: 8]    = 8'h22;
    data_credit[3*12 +: 12] = 12'h0FF;
    repeat (10) @(negedge clk);
    dllp_ready = 1'b1;
    repeat (10) @(negedge clk);

    // refresh timer only
    repeat (80) @(negedge clk);

    // drop DL_Active while a DLLP is stalled
    dllp_ready = 1'b0;
    waited = 0;
    while (!dllp_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (!dllp_valid) begin
      errors++;
      $display("FAIL stall_wait: got valid=0 expected valid=1 within 100 cycles");
    end
    dlc_state = 2'b00;
    @(posedge clk); #1;
    check("drop_valid", dllp_valid, 1'b0);
    @(negedge clk);
    dllp_ready = 1'b1;
    dlc_state  = 2'b11;
    repeat (20) @(negedge clk);

    // reset mid-burst
    dlc_state = 2'b00;
    repeat (2) @(negedge clk);
    dlc_state = 2'b11;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    dlc_state = 2'b00;
    @(posedge clk); #1;
    check("midrst_valid", dllp_valid, 1'b0);
    check("midrst_dllp", dllp, 136'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_idle", dllp_valid, 1'b0);
    dlc_state = 2'b11;
    repeat (20) @(negedge clk);

    // randomized traffic
    off_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      dllp_ready = ($urandom % 4) != 0;
      rst        = ($urandom % 500) == 0;
      if (off_cnt > 0) begin
        dlc_state = 2'($urandom_range(0, 2));
        off_cnt--;
      end else begin
        dlc_state = 2'b11;
        if ($urandom % 200 == 0) off_cnt = $urandom_range(1, 4);
      end
      if ($urandom % 8 == 0) begin
        slot = $urandom_range(0, NS - 1);
        hdr_credit[slot*8 +: 8]    = 8'($urandom);
        data_credit[slot*12 +: 12] = 12'($urandom);
      end
      @(negedge clk);
    end

    rst = 1'b0; dlc_state = 2'b11; dllp_ready = 1'b1;
    repeat (12) @(negedge clk);
    dlc_state = 2'b00;
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d outstanding expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
